mac_load_sequencer: RTL

Controller that sequences the nibble-loaded 8×8 multiply datapath into a multiply-accumulate engine on the Tiny Tapeout pin budget. It synchronizes the strobe inputs and assembles nibbles into an input operand and a weight operand. It then runs a registered multiply and accumulate step and exposes the accumulator, pair count and status bytes over the output pins. It sits directly behind the top-level pin interface and owns all operand and accumulator state.

---
 rtl/mac_seq_pkg.sv | 25 ++
 rtl/sync_edge.sv | 31 +++
 rtl/mac_load_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared constants for the nibble-loaded multiply-accumulate sequencer:
// FSM state codes, read-pointer selects, status bit positions.
package mac_seq_pkg;

  localparam logic [2:0] ST_LD_IN_LO = 3'd0;
  localparam logic [2:0] ST_LD_IN_HI = 3'd1;
  localparam logic [2:0] ST_LD_W_LO  = 3'd2;
  localparam logic [2:0] ST_LD_W_HI  = 3'd3;
  localparam logic [2:0] ST_MUL      = 3'd4;
  localparam logic [2:0] ST_ACC      = 3'd5;

  localparam logic [1:0] RD_ACC0 = 2'd0;
  localparam logic [1:0] RD_ACC1 = 2'd1;
  localparam logic [1:0] RD_ACC2 = 2'd2;
  localparam logic [1:0] RD_CNT  = 2'd3;

  localparam int unsigned STAT_ST   = 0;
  localparam int unsigned STAT_SAT  = 3;
  localparam int unsigned STAT_OVR  = 4;
  localparam int unsigned STAT_PTR  = 5;
  localparam int unsigned STAT_BUSY = 7;

  localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with rising-edge detect on the synchronized level.
// clr_i masks edges; history keeps tracking so nothing is pending afterwards.
module sync_edge #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;
  logic [WIDTH-1:0]             prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
      prev_q  <= level_o;
    end
  end

  assign level_o = chain_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q & ~{WIDTH{clr_i}};

endmodule

// File: rtl/mac_load_sequencer.sv
// Nibble-loaded 8x8 multiply-accumulate controller behind the pin interface.
// Owns operand, product, accumulator, count and read-pointer state.
module mac_load_sequencer
  import mac_seq_pkg::*;
#(
  parameter int ACC_W       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [5:0] lvl;
  logic [5:0] lvl_rise;
  logic       stb_ev;
  logic       rd_ev;
  logic       stb_lvl;
  logic       rd_lvl;

  logic [3:0] nib;
  logic       clr;
  logic       mode;

  assign nib  = lvl[3:0];
  assign clr  = lvl[4];
  assign mode = lvl[5];

  sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(6)) u_lvl (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (1'b0),
    .d_i     ({ui_in[7], ui_in[5], ui_in[3:0]}),
    .level_o (lvl),
    .rise_o  (lvl_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_stb (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .d_i     (ui_in[4]),
    .level_o (stb_lvl),
    .rise_o  (stb_ev)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_rd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .d_i     (ui_in[6]),
    .level_o (rd_lvl),
    .rise_o  (rd_ev)
  );

  logic [2:0]       state_q, state_d;
  logic [7:0]       in_q, in_d;
  logic [7:0]       w_q, w_d;
  logic [15:0]      prod_q, prod_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             ovr_q, ovr_d;
  logic [1:0]       ptr_q, ptr_d;

  logic             busy;
  logic [ACC_W:0]   acc_sum;

  assign busy    = (state_q == ST_MUL) || (state_q == ST_ACC);
  assign acc_sum = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, prod_q};

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    w_d     = w_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    ovr_d   = ovr_q;
    ptr_d   = ptr_q;
    if (clr) begin
      state_d = ST_LD_IN_LO;
      in_d    = '0;
      w_d     = '0;
      prod_d  = '0;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
      ovr_d   = 1'b0;
      ptr_d   = RD_ACC0;
    end else begin
      if (rd_ev) ptr_d = ptr_q + 2'd1;
      if (stb_ev && busy) ovr_d = 1'b1;
      unique case (state_q)
        ST_LD_IN_LO: if (stb_ev) begin
          in_d[3:0] = nib;
          state_d   = ST_LD_IN_HI;
        end
        ST_LD_IN_HI: if (stb_ev) begin
          in_d[7:4] = nib;
          state_d   = ST_LD_W_LO;
        end
        ST_LD_W_LO: if (stb_ev) begin
          w_d[3:0] = nib;
          state_d  = ST_LD_W_HI;
        end
        ST_LD_W_HI: if (stb_ev) begin
          w_d[7:4] = nib;
          state_d  = ST_MUL;
        end
        ST_MUL: begin
          prod_d  = 16'(in_q) * 16'(w_q);
          state_d = ST_ACC;
        end
        ST_ACC: begin
          if (mode) begin
            acc_d = {{(ACC_W-16){1'b0}}, prod_q};
          end else if (acc_sum[ACC_W]) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d = acc_sum[ACC_W-1:0];
          end
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
          state_d = ST_LD_IN_LO;
        end
        default: state_d = ST_LD_IN_LO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LD_IN_LO;
      in_q    <= '0;
      w_q     <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ptr_q   <= RD_ACC0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      w_q     <= w_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    unique case (ptr_q)
      RD_ACC0: uo_out = acc_q[7:0];
      RD_ACC1: uo_out = acc_q[15:8];
      RD_ACC2: uo_out = 8'(acc_q[ACC_W-1:16]);
      default: uo_out = cnt_q;
    endcase
  end

  always_comb begin
    uio_out                 = '0;
    uio_out[STAT_ST+:3]     = state_q;
    uio_out[STAT_SAT]       = sat_q;
    uio_out[STAT_OVR]       = ovr_q;
    uio_out[STAT_PTR+:2]    = ptr_q;
    uio_out[STAT_BUSY]      = busy;
  end

  assign uio_oe = 8'hFF;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, lvl_rise, stb_lvl, rd_lvl};

endmodule
